// File: rtl/rv32i_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rf_pkg
// Description : Shared sizes and requester encoding for the RF write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int IDX_W = 5;

    typedef enum logic [0:0] {
        REQ_WB = 1'b0,
        REQ_LD = 1'b1
    } req_e;

endpackage : rv32i_rf_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter (ALU writeback vs. load).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import rv32i_rf_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_wb_i,
    input  logic req_ld_i,
    output logic gnt_wb_o,
    output logic gnt_ld_o
);

    req_e prio_q;
    req_e prio_d;

    always_comb begin
        gnt_wb_o = 1'b0;
        gnt_ld_o = 1'b0;
        prio_d   = prio_q;
        if (!rst_i) begin
            if (req_wb_i && req_ld_i) begin
                // Contended cycle: winner hands priority to the loser.
                if (prio_q == REQ_WB) begin
                    gnt_wb_o = 1'b1;
                    prio_d   = REQ_LD;
                end else begin
                    gnt_ld_o = 1'b1;
                    prio_d   = REQ_WB;
                end
            end else begin
                gnt_wb_o = req_wb_i;
                gnt_ld_o = req_ld_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= REQ_WB;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/rv32i_rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rf_write_scheduler
// Description : Register-file write scheduler: scoreboard, WAW/RAW hazard
//               flags and arbitration of ALU/load writebacks onto one port.
//               Optional same-cycle forwarding: define RV32I_RF_FORWARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_rf_write_scheduler
    import rv32i_rf_pkg::*;
#(
    parameter int XLEN = rv32i_rf_pkg::XLEN,
    parameter int NREG = rv32i_rf_pkg::NREG
) (
    input  logic             sys_clk_i,
    input  logic             sys_reset_i,
    input  logic             issue_valid_i,
    input  logic [IDX_W-1:0] issue_rd_i,
    output logic             issue_ready_o,
    input  logic [IDX_W-1:0] rs1_i,
    input  logic [IDX_W-1:0] rs2_i,
    output logic             rs1_busy_o,
    output logic             rs2_busy_o,
    input  logic             wb_valid_i,
    input  logic [IDX_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic             wb_ready_o,
    input  logic             ld_valid_i,
    input  logic [IDX_W-1:0] ld_rd_i,
    input  logic [XLEN-1:0]  ld_data_i,
    output logic             ld_ready_o,
    output logic             rf_we_o,
    output logic [IDX_W-1:0] rf_rd_o,
    output logic [XLEN-1:0]  rf_indata_o,
    output logic             fwd1_valid_o,
    output logic [XLEN-1:0]  fwd1_data_o,
    output logic             fwd2_valid_o,
    output logic [XLEN-1:0]  fwd2_data_o,
    output logic [NREG-1:0]  busy_vec_o
);

    logic            gnt_wb;
    logic            gnt_ld;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_view;

    rr_arbiter2 u_arb (
        .clk_i    (sys_clk_i),
        .rst_i    (sys_reset_i),
        .req_wb_i (wb_valid_i),
        .req_ld_i (ld_valid_i),
        .gnt_wb_o (gnt_wb),
        .gnt_ld_o (gnt_ld)
    );

    always_comb begin
        rf_rd_o     = '0;
        rf_indata_o = '0;
        if (gnt_wb) begin
            rf_rd_o     = wb_rd_i;
            rf_indata_o = wb_data_i;
        end else if (gnt_ld) begin
            rf_rd_o     = ld_rd_i;
            rf_indata_o = ld_data_i;
        end
    end

    assign rf_we_o    = (gnt_wb || gnt_ld) && (rf_rd_o != '0);
    assign wb_ready_o = gnt_wb;
    assign ld_ready_o = gnt_ld;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_clr
            assign clr_vec[i] = rf_we_o && (rf_rd_o == IDX_W'(i));
        end
    endgenerate

`ifdef RV32I_RF_FORWARD_EN
    assign busy_view    = busy_q & ~clr_vec;
    assign fwd1_valid_o = rf_we_o && (rf_rd_o == rs1_i);
    assign fwd2_valid_o = rf_we_o && (rf_rd_o == rs2_i);
    assign fwd1_data_o  = fwd1_valid_o ? rf_indata_o : '0;
    assign fwd2_data_o  = fwd2_valid_o ? rf_indata_o : '0;
`else
    assign busy_view    = busy_q;
    assign fwd1_valid_o = 1'b0;
    assign fwd2_valid_o = 1'b0;
    assign fwd1_data_o  = '0;
    assign fwd2_data_o  = '0;
`endif

    assign issue_ready_o = !sys_reset_i && ((issue_rd_i == '0) || !busy_view[issue_rd_i]);
    assign rs1_busy_o    = (rs1_i != '0) && busy_view[rs1_i];
    assign rs2_busy_o    = (rs2_i != '0) && busy_view[rs2_i];

    assign set_vec = (issue_valid_i && issue_ready_o && (issue_rd_i != '0))
                     ? (NREG'(1) << issue_rd_i) : '0;
    // Set is ORed after the clear so an issue wins over a same-cycle writeback.
    assign busy_d  = ((busy_q & ~clr_vec) | set_vec) & ~NREG'(1);

    always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule : rv32i_rf_write_scheduler
`default_nettype wire

// File: tb/tb_rv32i_rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_rf_write_scheduler
// Description : Directed scoreboard bench for the RF write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        wb_valid, ld_valid;
    logic [4:0]  wb_rd, ld_rd;
    logic [31:0] wb_data, ld_data;
    logic        wb_ready, ld_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_indata;
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
    logic [31:0] busy_vec;

    typedef struct {
        logic        wb;
        logic        ld;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    rv32i_rf_write_scheduler dut (
        .sys_clk_i     (clk),
        .sys_reset_i   (rst),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .rs1_busy_o    (rs1_busy),
        .rs2_busy_o    (rs2_busy),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .wb_ready_o    (wb_ready),
        .ld_valid_i    (ld_valid),
        .ld_rd_i       (ld_rd),
        .ld_data_i     (ld_data),
        .ld_ready_o    (ld_ready),
        .rf_we_o       (rf_we),
        .rf_rd_o       (rf_rd),
        .rf_indata_o   (rf_indata),
        .fwd1_valid_o  (fwd1_valid),
        .fwd1_data_o   (fwd1_data),
        .fwd2_valid_o  (fwd2_valid),
        .fwd2_data_o   (fwd2_data),
        .busy_vec_o    (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic wb, input logic ld, input logic we,
                           input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.wb = wb; e.ld = ld; e.we = we; e.rd = rd; e.data = data;
        wr_q.push_back(e);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
    endtask

    // Write-port monitor: every grant pops one expected write.
    always @(negedge clk) begin
        if (wb_ready || ld_ready) begin
            if (wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_grant: got wb=%0b ld=%0b rd=%0d, expected no grant",
                         wb_ready, ld_ready, rf_rd);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("grant_wb",  {31'd0, wb_ready}, {31'd0, e.wb});
                chk("grant_ld",  {31'd0, ld_ready}, {31'd0, e.ld});
                chk("rf_we",     {31'd0, rf_we},    {31'd0, e.we});
                chk("rf_rd",     {27'd0, rf_rd},    {27'd0, e.rd});
                chk("rf_indata", rf_indata,         e.data);
            end
        end else begin
            chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        // Reset with requests pending: nothing may be accepted.
        wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
        ld_valid = 1; ld_rd = 4; ld_data = 32'h44;
        issue_valid = 1; issue_rd = 5;
        #4;
        chk("rst_issue_ready", {31'd0, issue_ready}, 0);
        chk("rst_wb_ready",    {31'd0, wb_ready},    0);
        chk("rst_ld_ready",    {31'd0, ld_ready},    0);
        chk("rst_rf_we",       {31'd0, rf_we},       0);
        chk("rst_busy_vec",    busy_vec,             0);
        cyc(); rst = 0; idle();

        // WAW: issue rd5, reissue blocked, writeback clears.
        cyc(); issue_valid = 1; issue_rd = 5;
        #3 chk("issue5_ready", {31'd0, issue_ready}, 1);
        cyc();
        #3 chk("issue5_again_ready", {31'd0, issue_ready}, 0);
        chk("busy5_set", busy_vec, 32'h20);
        cyc(); idle(); wb_valid = 1; wb_rd = 5; wb_data = 32'h1234;
        push_wr(1, 0, 1, 5, 32'h1234);
        #3 chk("busy5_before_clr", busy_vec, 32'h20);
        cyc(); idle();
        #3 chk("busy5_cleared", busy_vec, 0);

        // Contention: alternates wb, ld, wb, ld.
        for (int i = 0; i < 4; i++) begin
            cyc();
            wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
            ld_valid = 1; ld_rd = 4; ld_data = 32'h44;
            if (i % 2 == 0) push_wr(1, 0, 1, 3, 32'h33);
            else            push_wr(0, 1, 1, 4, 32'h44);
        end
        cyc(); idle(); issue_valid = 1; issue_rd = 7;

        // Load to x0: consumed, no RF write, scoreboard untouched.
        cyc(); idle(); ld_valid = 1; ld_rd = 0; ld_data = 32'hFFFF_FFFF;
        push_wr(0, 1, 0, 0, 32'hFFFF_FFFF);
        #3 chk("busy7_set", busy_vec, 32'h80);
        cyc(); idle(); rs1 = 7;
        #3 chk("busy_after_x0", busy_vec, 32'h80);
        chk("rs1_busy_no_wr", {31'd0, rs1_busy},   1);
        chk("fwd1_valid_no_wr", {31'd0, fwd1_valid}, 0);

        // RAW against a same-cycle writeback.
        cyc(); rs1 = 7; rs2 = 0; wb_valid = 1; wb_rd = 7; wb_data = 32'hA5;
        push_wr(1, 0, 1, 7, 32'hA5);
        #3;
        chk("rs2_busy_x0", {31'd0, rs2_busy}, 0);
`ifdef RV32I_RF_FORWARD_EN
        chk("rs1_busy_fwd",  {31'd0, rs1_busy},   0);
        chk("fwd1_valid",    {31'd0, fwd1_valid}, 1);
        chk("fwd1_data",     fwd1_data,           32'hA5);
`else
        chk("rs1_busy_nofwd",  {31'd0, rs1_busy},   1);
        chk("fwd1_valid_tied", {31'd0, fwd1_valid}, 0);
        chk("fwd1_data_tied",  fwd1_data,           0);
`endif

        // Unsolicited write racing an issue to the same rd: set wins.
        cyc(); idle(); issue_valid = 1; issue_rd = 9;
        wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
        push_wr(1, 0, 1, 9, 32'h99);
        #3 chk("busy7_cleared", busy_vec, 0);
        chk("issue9_ready", {31'd0, issue_ready}, 1);
        cyc(); idle(); issue_valid = 1; issue_rd = 10;
        #3 chk("busy9_set_wins", busy_vec, 32'h200);

        // Contended grant to wb moves priority to ld, then reset mid-contention.
        cyc(); idle(); wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
        ld_valid = 1; ld_rd = 4; ld_data = 32'h44;
        push_wr(1, 0, 1, 3, 32'h33);
        #3 chk("busy_before_rst", busy_vec, 32'h600);
        cyc(); rst = 1; issue_valid = 1; issue_rd = 11; rs1 = 10;
        #3;
        chk("mid_rst_busy_vec",    busy_vec,              0);
        chk("mid_rst_issue_ready", {31'd0, issue_ready},  0);
        chk("mid_rst_wb_ready",    {31'd0, wb_ready},     0);
        chk("mid_rst_ld_ready",    {31'd0, ld_ready},     0);
        chk("mid_rst_rf_we",       {31'd0, rf_we},        0);
        chk("mid_rst_fwd",         {30'd0, fwd1_valid, fwd2_valid}, 0);
        cyc(); rst = 0; issue_valid = 0;
        push_wr(1, 0, 1, 3, 32'h33);
        cyc(); idle();
        #20;
        chk("scoreboard_drained", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rv32i_rf_write_scheduler
`default_nettype wire
